store_write_buffer: RTL and testbench

- Posted-store buffer between the EX/MEM pipeline register and the data memory, which writes on the negedge and reads combinationally.
- Accepts stores from the pipeline and queues them in FIFO order.
- Drains queued stores to memory in cycles where no load needs the memory port.
- Forwards word data to loads that hit a buffered word store; stalls the pipeline on partial-overlap hazards until the conflicting store has drained.

---
 rtl/store_write_buffer.sv | 166 ++++++++++++++++
 tb/tb_store_write_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-store FIFO between EX/MEM and the data memory.
// Stores queue in order and drain when no plain load claims the memory port.
// A load that hits a buffered word store gets that word forwarded. A load
// that overlaps a buffered store in any other way stalls until the store drains.
module store_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          StoreValid,
  input  logic [AW-1:0] StoreAddr,
  input  logic [DW-1:0] StoreData,
  input  logic [1:0]    StoreSize,
  output logic          StoreReady,
  input  logic          LoadValid,
  input  logic [AW-1:0] LoadAddr,
  input  logic [1:0]    LoadSize,
  output logic          LoadFwd,
  output logic [DW-1:0] LoadFwdData,
  output logic          Stall,
  output logic [AW-1:0] MemAddress,
  output logic [DW-1:0] MemWriteData,
  output logic          MemWrite,
  output logic          MemRead,
  output logic [4:0]    MemAluCode
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [1:0] SZ_W = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_B = 2'b10;

  localparam logic [4:0] ALU_SW = 5'b00000;
  localparam logic [4:0] ALU_SH = 5'b01001;
  localparam logic [4:0] ALU_SB = 5'b00110;
  localparam logic [4:0] ALU_LW = 5'b00000;
  localparam logic [4:0] ALU_LH = 5'b00111;
  localparam logic [4:0] ALU_LB = 5'b01000;

  // Entry storage
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [1:0]    size_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push_c;
  logic          pop_c;
  logic          match_c;
  logic [1:0]    ym_size_c;
  logic [DW-1:0] ym_data_c;
  logic [PW-1:0] slot_c;
  logic          fwd_c;
  logic          conflict_c;
  logic          plain_load_c;

  // Store size to memory alu code (11 behaves as a word store)
  function automatic logic [4:0] store_code(input logic [1:0] sz);
    case (sz)
      SZ_H:    store_code = ALU_SH;
      SZ_B:    store_code = ALU_SB;
      default: store_code = ALU_SW;
    endcase
  endfunction

  // Load size to memory alu code
  function automatic logic [4:0] load_code(input logic [1:0] sz);
    case (sz)
      SZ_H:    load_code = ALU_LH;
      SZ_B:    load_code = ALU_LB;
      default: load_code = ALU_LW;
    endcase
  endfunction

  assign StoreReady = (count_q < CW'(DEPTH));
  assign push_c     = StoreValid && StoreReady;

  // Youngest-match search: walk from head to tail so later hits override
  always_comb begin
    match_c   = 1'b0;
    ym_size_c = SZ_W;
    ym_data_c = '0;
    slot_c    = head_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      slot_c = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[slot_c][11:2] == LoadAddr[11:2])) begin
        match_c   = 1'b1;
        ym_size_c = size_q[slot_c];
        ym_data_c = data_q[slot_c];
      end
    end
  end

  // Classify the load: forward, conflict, or plain memory read
  always_comb begin
    fwd_c        = LoadValid && match_c &&
                   ((ym_size_c == SZ_W) || (ym_size_c == 2'b11)) &&
                   (LoadSize == SZ_W);
    conflict_c   = LoadValid && match_c && !fwd_c;
    plain_load_c = LoadValid && !match_c;
    pop_c        = (count_q != '0) && !plain_load_c;
  end

  // Pipeline-facing and memory-port outputs
  always_comb begin
    LoadFwd      = fwd_c;
    LoadFwdData  = fwd_c ? ym_data_c : '0;
    Stall        = conflict_c || (StoreValid && !StoreReady);
    MemAddress   = '0;
    MemWriteData = '0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    MemAluCode   = 5'b00000;
    if (plain_load_c) begin
      MemRead    = 1'b1;
      MemAddress = LoadAddr;
      MemAluCode = load_code(LoadSize);
    end else if (pop_c) begin
      MemWrite     = 1'b1;
      MemAddress   = addr_q[head_q];
      MemWriteData = data_q[head_q];
      MemAluCode   = store_code(size_q[head_q]);
    end
  end

  // Pointer and occupancy next state
  always_comb begin
    head_d  = pop_c  ? head_q + PW'(1) : head_q;
    tail_d  = push_c ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset discards everything buffered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry write at tail on an accepted store
  always_ff @(posedge clk) begin
    if (push_c) begin
      addr_q[tail_q] <= StoreAddr;
      data_q[tail_q] <= StoreData;
      size_q[tail_q] <= StoreSize;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: a queue of expected memory writes is filled as
// stores are driven and drained by a negedge monitor whenever MemWrite is seen.
`timescale 1ns/1ps
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StoreValid;
  logic [31:0] StoreAddr;
  logic [31:0] StoreData;
  logic [1:0]  StoreSize;
  logic        StoreReady;
  logic        LoadValid;
  logic [31:0] LoadAddr;
  logic [1:0]  LoadSize;
  logic        LoadFwd;
  logic [31:0] LoadFwdData;
  logic        Stall;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [4:0]  MemAluCode;

  always #5 clk = ~clk;

  store_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .StoreValid  (StoreValid),
    .StoreAddr   (StoreAddr),
    .StoreData   (StoreData),
    .StoreSize   (StoreSize),
    .StoreReady  (StoreReady),
    .LoadValid   (LoadValid),
    .LoadAddr    (LoadAddr),
    .LoadSize    (LoadSize),
    .LoadFwd     (LoadFwd),
    .LoadFwdData (LoadFwdData),
    .Stall       (Stall),
    .MemAddress  (MemAddress),
    .MemWriteData(MemWriteData),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .MemAluCode  (MemAluCode)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  code;
  } wr_t;

  wr_t sb_q[$];
  wr_t mon_e;
  int  n_checks  = 0;
  int  n_fail    = 0;
  int  n_overlap = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] st_code(input logic [1:0] sz);
    case (sz)
      2'b01:   st_code = 5'b01001;
      2'b10:   st_code = 5'b00110;
      default: st_code = 5'b00000;
    endcase
  endfunction

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                    input bit expect_accept);
    wr_t e;
    StoreValid = 1'b1;
    StoreAddr  = a;
    StoreData  = d;
    StoreSize  = sz;
    if (expect_accept) begin
      e.addr = a;
      e.data = d;
      e.code = st_code(sz);
      sb_q.push_back(e);
    end
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sz);
    LoadValid = 1'b1;
    LoadAddr  = a;
    LoadSize  = sz;
  endtask

  task automatic idle();
    StoreValid = 1'b0;
    StoreAddr  = '0;
    StoreData  = '0;
    StoreSize  = '0;
    LoadValid  = 1'b0;
    LoadAddr   = '0;
    LoadSize   = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: every MemWrite must match the oldest outstanding store
  always @(negedge clk) begin
    if (StoreValid && LoadValid) n_overlap++;
    if (MemWrite === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", MemWrite, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_addr", MemAddress, mon_e.addr);
        check("wr_data", MemWriteData, mon_e.data);
        check("wr_code", MemAluCode, mon_e.code);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state: empty buffer, no requests
    @(negedge clk);
    check("rst_ready", StoreReady, 1);
    check("rst_stall", Stall, 0);
    check("rst_fwd", LoadFwd, 0);
    check("rst_fwd_data", LoadFwdData, 0);
    check("rst_addr", MemAddress, 0);
    check("rst_wdata", MemWriteData, 0);
    check("rst_mw", MemWrite, 0);
    check("rst_mr", MemRead, 0);
    check("rst_code", MemAluCode, 0);
    next();

    // Single sw drains the cycle after enqueue
    st(32'h10, 32'hDEADBEEF, 2'b00, 1);
    @(negedge clk); check("t1_enq_mw", MemWrite, 0);
    next(); idle();
    @(negedge clk); check("t1_drain_mw", MemWrite, 1);
    next();
    @(negedge clk); check("t1_after_mw", MemWrite, 0); check("t1_after_rdy", StoreReady, 1);
    next();

    // Fill while a non-matching load owns the port
    ld(32'h200, 2'b00);
    for (int k = 0; k < 4; k++) begin
      st(32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k), 2'b00, 1);
      @(negedge clk);
      check("t2_fill_rdy", StoreReady, 1);
      check("t2_fill_mr", MemRead, 1);
      check("t2_fill_addr", MemAddress, 32'h200);
      check("t2_fill_mw", MemWrite, 0);
      next();
    end
    st(32'h110, 32'hFFFF_0000, 2'b00, 0);
    @(negedge clk);
    check("t2_full_rdy", StoreReady, 0);
    check("t2_full_stall", Stall, 1);
    next(); idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_drain_mw", MemWrite, 1);
      if (k == 0) check("t2_drain_full_rdy", StoreReady, 0);
      next();
    end
    @(negedge clk); check("t2_empty_mw", MemWrite, 0);
    next();

    // Pointer wrap: enqueue two more, second overlapping the first drain
    st(32'h120, 32'hB000_0001, 2'b00, 1);
    @(negedge clk); check("t2w_c0_mw", MemWrite, 0);
    next();
    st(32'h124, 32'h0000_BEEF, 2'b01, 1);
    @(negedge clk); check("t2w_c1_mw", MemWrite, 1);
    next(); idle();
    @(negedge clk); check("t2w_c2_mw", MemWrite, 1);
    next();
    @(negedge clk); check("t2w_c3_mw", MemWrite, 0); check("t2w_c3_rdy", StoreReady, 1);
    next();

    // Forwarding from the youngest of two word stores
    ld(32'h200, 2'b00);
    st(32'h40, 32'h1111_1111, 2'b00, 1);
    next();
    st(32'h40, 32'h2222_2222, 2'b00, 1);
    next();
    idle();
    ld(32'h40, 2'b00);
    @(negedge clk);
    check("t3_fwd", LoadFwd, 1);
    check("t3_fwd_data", LoadFwdData, 32'h2222_2222);
    check("t3_mr", MemRead, 0);
    check("t3_stall", Stall, 0);
    check("t3_drain", MemWrite, 1);
    next();
    @(negedge clk);
    check("t3_fwd2", LoadFwd, 1);
    check("t3_fwd2_data", LoadFwdData, 32'h2222_2222);
    next();
    @(negedge clk);
    check("t3_empty_fwd", LoadFwd, 0);
    check("t3_empty_mr", MemRead, 1);
    next(); idle();

    // Partial overlap: sb buffered, lw to same word stalls until drained
    ld(32'h200, 2'b00);
    st(32'h44, 32'h0000_00AB, 2'b10, 1);
    next();
    idle();
    ld(32'h44, 2'b00);
    @(negedge clk);
    check("t4_stall", Stall, 1);
    check("t4_mw", MemWrite, 1);
    check("t4_code", MemAluCode, 5'b00110);
    check("t4_mr", MemRead, 0);
    check("t4_fwd", LoadFwd, 0);
    next();
    @(negedge clk);
    check("t4_release_stall", Stall, 0);
    check("t4_release_mr", MemRead, 1);
    check("t4_release_addr", MemAddress, 32'h44);
    check("t4_release_mw", MemWrite, 0);
    next(); idle();

    // Reset mid-drain discards the remaining entries
    ld(32'h200, 2'b00);
    for (int k = 0; k < 3; k++) begin
      st(32'h300 + 32'(4 * k), 32'hC000_0000 + 32'(k), 2'b00, 1);
      next();
    end
    idle();
    @(negedge clk); check("t5_drain0", MemWrite, 1);
    next();
    rst_n = 1'b0;
    @(negedge clk); check("t5_rst_cycle_mw", MemWrite, 1);
    next();
    rst_n = 1'b1;
    sb_q.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_post_mw", MemWrite, 0);
      if (k == 0) check("t5_post_rdy", StoreReady, 1);
      next();
    end

    // Plain halfword and byte loads on an empty buffer
    ld(32'h80, 2'b01);
    @(negedge clk);
    check("t6_lh_mr", MemRead, 1);
    check("t6_lh_code", MemAluCode, 5'b00111);
    check("t6_lh_addr", MemAddress, 32'h80);
    check("t6_lh_fwd", LoadFwd, 0);
    check("t6_lh_stall", Stall, 0);
    next();
    ld(32'h81, 2'b10);
    @(negedge clk);
    check("t6_lb_code", MemAluCode, 5'b01000);
    check("t6_lb_mw", MemWrite, 0);
    next(); idle();
    next();

    check("sb_left", sb_q.size(), 0);
    $display("note: %0d cycles drove a store and a load together", n_overlap);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
